// File: rtl/ctrl_sequencer.sv
// Hardwired control unit for the single-bus datapath: fetch, decode IR[31:27] and
// drive one set of control strobes per T-state, with memory-ready wait states.
module ctrl_sequencer #(
    parameter logic [4:0] ALU_ADD = 5'b00011,
    parameter logic [4:0] ALU_AND = 5'b00101,
    parameter logic [4:0] ALU_OR  = 5'b00110
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        mem_ready,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRread,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        ZLowSelect,
    output logic        ZHighSelect,
    output logic        HIin,
    output logic        HIout,
    output logic        LOin,
    output logic        LOout,
    output logic        Cout,
    output logic        CON_ff_in,
    output logic [4:0]  ALU_opcode,
    output logic        Read,
    output logic        Write,
    output logic        run,
    output logic        illegal
);

    typedef enum logic [3:0] {
        ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_t;

    state_t state_q, state_d;

    logic [4:0] op;
    logic       is_alu_r, is_addi, is_andi, is_ori, is_imm;
    logic       is_ld, is_ldi, is_st, is_muldiv, is_br, is_jr;
    logic       is_mfhi, is_mflo, is_nop, is_halt, is_undef;
    logic       unused_ir_bits;

    assign op             = IR[31:27];
    assign unused_ir_bits = ^IR[26:0];

    assign is_alu_r  = (op >= 5'b00011) && (op <= 5'b01011);
    assign is_addi   = (op == 5'b01100);
    assign is_andi   = (op == 5'b01101);
    assign is_ori    = (op == 5'b01110);
    assign is_imm    = is_addi || is_andi || is_ori;
    assign is_ld     = (op == 5'b00000);
    assign is_ldi    = (op == 5'b00001);
    assign is_st     = (op == 5'b00010);
    assign is_muldiv = (op == 5'b01111) || (op == 5'b10000);
    assign is_br     = (op == 5'b10010);
    assign is_jr     = (op == 5'b10100);
    assign is_mfhi   = (op == 5'b11000);
    assign is_mflo   = (op == 5'b11001);
    assign is_nop    = (op == 5'b11010);
    assign is_halt   = (op == 5'b11011);
    assign is_undef  = !(is_alu_r || is_imm || is_ld || is_ldi || is_st || is_muldiv ||
                         is_br || is_jr || is_mfhi || is_mflo || is_nop || is_halt);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST: state_d = ST_T0;
            ST_T0:  state_d = ST_T1;
            ST_T1:  state_d = mem_ready ? ST_T2 : ST_T1;
            ST_T2:  state_d = ST_T3;
            ST_T3: begin
                if (is_halt) begin
                    state_d = ST_HALT;
                end else if (is_alu_r || is_imm || is_ld || is_ldi || is_st || is_muldiv || is_br) begin
                    state_d = ST_T4;
                end else begin
                    state_d = ST_T0;
                end
            end
            ST_T4:  state_d = ST_T5;
            ST_T5:  state_d = (is_ld || is_st || is_muldiv || is_br) ? ST_T6 : ST_T0;
            ST_T6: begin
                if (is_ld) begin
                    state_d = mem_ready ? ST_T7 : ST_T6;
                end else if (is_st) begin
                    state_d = ST_T7;
                end else begin
                    state_d = ST_T0;
                end
            end
            ST_T7: begin
                if (is_st && !mem_ready) begin
                    state_d = ST_T7;
                end else begin
                    state_d = ST_T0;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    // Exactly one bus driver per state; everything not named for a state stays low.
    always_comb begin
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
        MDRread = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
        ZLowSelect = 1'b0; ZHighSelect = 1'b0; HIin = 1'b0; HIout = 1'b0;
        LOin = 1'b0; LOout = 1'b0; Cout = 1'b0; CON_ff_in = 1'b0;
        ALU_opcode = 5'b00000; Read = 1'b0; Write = 1'b0;
        run = (state_q != ST_HALT);
        illegal = 1'b0;
        case (state_q)
            ST_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
            end
            ST_T1: begin
                Read = 1'b1; MDRread = 1'b1; MDRin = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            ST_T3: begin
                if (is_alu_r || is_imm) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_ld || is_ldi || is_st) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (is_muldiv) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_br) begin
                    Gra = 1'b1; Rout = 1'b1; CON_ff_in = 1'b1;
                end else if (is_jr) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                end else if (is_mfhi) begin
                    HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_mflo) begin
                    LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_undef) begin
                    illegal = 1'b1;
                end
            end
            ST_T4: begin
                if (is_alu_r) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_opcode = op;
                end else if (is_imm) begin
                    Cout = 1'b1; Zin = 1'b1;
                    ALU_opcode = is_andi ? ALU_AND : (is_ori ? ALU_OR : ALU_ADD);
                end else if (is_ld || is_ldi || is_st) begin
                    Cout = 1'b1; Zin = 1'b1; ALU_opcode = ALU_ADD;
                end else if (is_muldiv) begin
                    Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_opcode = op;
                end else if (is_br) begin
                    PCout = 1'b1; Yin = 1'b1;
                end
            end
            ST_T5: begin
                if (is_alu_r || is_imm || is_ldi) begin
                    ZLowSelect = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_ld || is_st) begin
                    ZLowSelect = 1'b1; MARin = 1'b1;
                end else if (is_muldiv) begin
                    ZLowSelect = 1'b1; LOin = 1'b1;
                end else if (is_br) begin
                    Cout = 1'b1; Zin = 1'b1; ALU_opcode = ALU_ADD;
                end
            end
            ST_T6: begin
                if (is_ld) begin
                    Read = 1'b1; MDRread = 1'b1; MDRin = 1'b1;
                end else if (is_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (is_muldiv) begin
                    ZHighSelect = 1'b1; HIin = 1'b1;
                end else if (is_br && CON) begin
                    ZLowSelect = 1'b1; PCin = 1'b1;
                end
            end
            ST_T7: begin
                if (is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_st) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: walks each instruction class through its
// T-states and compares the full strobe vector against hand-computed values.
module tb_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] IR = 32'h0;
    logic        CON = 1'b0;
    logic        mem_ready = 1'b1;

    logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin, MDRread;
    logic MDRout, IRin, Yin, Zin, ZLowSelect, ZHighSelect, HIin, HIout, LOin, LOout;
    logic Cout, CON_ff_in, Read, Write, run, illegal;
    logic [4:0] ALU_opcode;

    int checkCount = 0;
    int errorCount = 0;

    localparam logic [32:0] M_GRA     = 33'd1 << 27;
    localparam logic [32:0] M_GRB     = 33'd1 << 26;
    localparam logic [32:0] M_GRC     = 33'd1 << 25;
    localparam logic [32:0] M_RIN     = 33'd1 << 24;
    localparam logic [32:0] M_ROUT    = 33'd1 << 23;
    localparam logic [32:0] M_BAOUT   = 33'd1 << 22;
    localparam logic [32:0] M_PCOUT   = 33'd1 << 21;
    localparam logic [32:0] M_PCIN    = 33'd1 << 20;
    localparam logic [32:0] M_INCPC   = 33'd1 << 19;
    localparam logic [32:0] M_MARIN   = 33'd1 << 18;
    localparam logic [32:0] M_MDRIN   = 33'd1 << 17;
    localparam logic [32:0] M_MDRREAD = 33'd1 << 16;
    localparam logic [32:0] M_MDROUT  = 33'd1 << 15;
    localparam logic [32:0] M_IRIN    = 33'd1 << 14;
    localparam logic [32:0] M_YIN     = 33'd1 << 13;
    localparam logic [32:0] M_ZIN     = 33'd1 << 12;
    localparam logic [32:0] M_ZLOW    = 33'd1 << 11;
    localparam logic [32:0] M_ZHIGH   = 33'd1 << 10;
    localparam logic [32:0] M_HIIN    = 33'd1 << 9;
    localparam logic [32:0] M_HIOUT   = 33'd1 << 8;
    localparam logic [32:0] M_LOIN    = 33'd1 << 7;
    localparam logic [32:0] M_LOOUT   = 33'd1 << 6;
    localparam logic [32:0] M_COUT    = 33'd1 << 5;
    localparam logic [32:0] M_CONIN   = 33'd1 << 4;
    localparam logic [32:0] M_READ    = 33'd1 << 3;
    localparam logic [32:0] M_WRITE   = 33'd1 << 2;
    localparam logic [32:0] M_RUN     = 33'd1 << 1;
    localparam logic [32:0] M_ILL     = 33'd1 << 0;

    logic [32:0] observed;
    assign observed = {ALU_opcode, Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC,
                       MARin, MDRin, MDRread, MDRout, IRin, Yin, Zin, ZLowSelect,
                       ZHighSelect, HIin, HIout, LOin, LOout, Cout, CON_ff_in,
                       Read, Write, run, illegal};

    ctrl_sequencer dut (
        .clk(clk), .clr(clr), .IR(IR), .CON(CON), .mem_ready(mem_ready),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRread(MDRread), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .ZLowSelect(ZLowSelect), .ZHighSelect(ZHighSelect), .HIin(HIin), .HIout(HIout),
        .LOin(LOin), .LOout(LOout), .Cout(Cout), .CON_ff_in(CON_ff_in),
        .ALU_opcode(ALU_opcode), .Read(Read), .Write(Write), .run(run), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] alu(input logic [4:0] op);
        return {op, 28'd0};
    endfunction

    task automatic checkOutput(input string tag, input logic [32:0] actual, input logic [32:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] ir, input logic con, input logic mr);
        IR = ir;
        CON = con;
        mem_ready = mr;
    endtask

    // Called while sitting in T0; returns sampling the first cycle of T3.
    task automatic doFetch(input string name, input logic [31:0] ir, input int waits);
        checkOutput({name, "_t0"}, observed, M_PCOUT | M_MARIN | M_INCPC | M_RUN);
        step;
        for (int i = 0; i < waits; i++) begin
            mem_ready = 1'b0;
            checkOutput({name, "_t1wait"}, observed, M_READ | M_MDRREAD | M_MDRIN | M_RUN);
            step;
        end
        mem_ready = 1'b1;
        checkOutput({name, "_t1"}, observed, M_READ | M_MDRREAD | M_MDRIN | M_RUN);
        step;
        checkOutput({name, "_t2"}, observed, M_MDROUT | M_IRIN | M_RUN);
        IR = ir;
        step;
    endtask

    initial begin
        applyStimulus(32'hFFFF_FFFF, 1'b1, 1'b1);
        clr = 1'b0;
        repeat (3) step;
        checkOutput("reset_hold", observed, M_RUN);
        clr = 1'b1;
        #1;
        checkOutput("rst_state", observed, M_RUN);
        step;

        // add with two wait states in fetch
        applyStimulus(32'h0, 1'b0, 1'b1);
        doFetch("add", 32'h18918000, 2);
        checkOutput("add_t3", observed, M_GRB | M_ROUT | M_YIN | M_RUN);
        step;
        checkOutput("add_t4", observed, M_GRC | M_ROUT | M_ZIN | M_RUN | alu(5'b00011));
        step;
        checkOutput("add_t5", observed, M_ZLOW | M_GRA | M_RIN | M_RUN);
        step;

        // st with one memory wait in T7; mem_ready low in T6 must be ignored
        doFetch("st", 32'h10000000, 0);
        checkOutput("st_t3", observed, M_GRB | M_BAOUT | M_YIN | M_RUN);
        step;
        checkOutput("st_t4", observed, M_COUT | M_ZIN | M_RUN | alu(5'b00011));
        step;
        checkOutput("st_t5", observed, M_ZLOW | M_MARIN | M_RUN);
        mem_ready = 1'b0;
        step;
        checkOutput("st_t6", observed, M_GRA | M_ROUT | M_MDRIN | M_RUN);
        step;
        checkOutput("st_t7a", observed, M_WRITE | M_RUN);
        step;
        checkOutput("st_t7b", observed, M_WRITE | M_RUN);
        mem_ready = 1'b1;
        step;

        // ld with one memory wait in T6
        doFetch("ld", 32'h00800000, 0);
        checkOutput("ld_t3", observed, M_GRB | M_BAOUT | M_YIN | M_RUN);
        step;
        checkOutput("ld_t4", observed, M_COUT | M_ZIN | M_RUN | alu(5'b00011));
        step;
        checkOutput("ld_t5", observed, M_ZLOW | M_MARIN | M_RUN);
        mem_ready = 1'b0;
        step;
        checkOutput("ld_t6a", observed, M_READ | M_MDRREAD | M_MDRIN | M_RUN);
        step;
        checkOutput("ld_t6b", observed, M_READ | M_MDRREAD | M_MDRIN | M_RUN);
        mem_ready = 1'b1;
        step;
        checkOutput("ld_t7", observed, M_MDROUT | M_GRA | M_RIN | M_RUN);
        step;

        // branch not taken, then taken
        for (int c = 0; c < 2; c++) begin
            CON = (c == 1);
            doFetch("br", 32'h90000000, 0);
            checkOutput("br_t3", observed, M_GRA | M_ROUT | M_CONIN | M_RUN);
            step;
            checkOutput("br_t4", observed, M_PCOUT | M_YIN | M_RUN);
            step;
            checkOutput("br_t5", observed, M_COUT | M_ZIN | M_RUN | alu(5'b00011));
            step;
            checkOutput(c == 1 ? "br_t6_taken" : "br_t6_not_taken", observed,
                        c == 1 ? (M_ZLOW | M_PCIN | M_RUN) : M_RUN);
            step;
        end
        CON = 1'b0;

        doFetch("andi", 32'h68000000, 0);
        checkOutput("andi_t3", observed, M_GRB | M_ROUT | M_YIN | M_RUN);
        step;
        checkOutput("andi_t4", observed, M_COUT | M_ZIN | M_RUN | alu(5'b00101));
        step;
        checkOutput("andi_t5", observed, M_ZLOW | M_GRA | M_RIN | M_RUN);
        step;

        doFetch("ori", 32'h70000000, 0);
        step;
        checkOutput("ori_t4", observed, M_COUT | M_ZIN | M_RUN | alu(5'b00110));
        step;
        step;

        doFetch("ldi", 32'h08000000, 0);
        checkOutput("ldi_t3", observed, M_GRB | M_BAOUT | M_YIN | M_RUN);
        step;
        step;
        checkOutput("ldi_t5", observed, M_ZLOW | M_GRA | M_RIN | M_RUN);
        step;

        doFetch("mul", 32'h78000000, 0);
        checkOutput("mul_t3", observed, M_GRA | M_ROUT | M_YIN | M_RUN);
        step;
        checkOutput("mul_t4", observed, M_GRB | M_ROUT | M_ZIN | M_RUN | alu(5'b01111));
        step;
        checkOutput("mul_t5", observed, M_ZLOW | M_LOIN | M_RUN);
        step;
        checkOutput("mul_t6", observed, M_ZHIGH | M_HIIN | M_RUN);
        step;

        doFetch("jr", 32'hA0000000, 0);
        checkOutput("jr_t3", observed, M_GRA | M_ROUT | M_PCIN | M_RUN);
        step;

        doFetch("mfhi", 32'hC0000000, 0);
        checkOutput("mfhi_t3", observed, M_HIOUT | M_GRA | M_RIN | M_RUN);
        step;

        doFetch("mflo", 32'hC8000000, 0);
        checkOutput("mflo_t3", observed, M_LOOUT | M_GRA | M_RIN | M_RUN);
        step;

        doFetch("nop", 32'hD0000000, 0);
        checkOutput("nop_t3", observed, M_RUN);
        step;

        doFetch("undef", 32'hF8000000, 0);
        checkOutput("undef_t3", observed, M_RUN | M_ILL);
        step;

        // reset in the middle of an add
        doFetch("abort", 32'h18918000, 0);
        step;
        #2;
        clr = 1'b0;
        #1;
        checkOutput("abort_async", observed, M_RUN);
        step;
        clr = 1'b1;
        #1;
        checkOutput("abort_rst", observed, M_RUN);
        step;

        // halt, then recover via reset
        doFetch("halt", 32'hD8000000, 0);
        checkOutput("halt_t3", observed, M_RUN);
        step;
        checkOutput("halt_a", observed, 33'd0);
        repeat (3) step;
        checkOutput("halt_b", observed, 33'd0);
        #2;
        clr = 1'b0;
        #1;
        checkOutput("halt_clr_async", observed, M_RUN);
        step;
        clr = 1'b1;
        #1;
        checkOutput("halt_rst", observed, M_RUN);
        step;
        checkOutput("halt_restart_t0", observed, M_PCOUT | M_MARIN | M_INCPC | M_RUN);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
